sram_ctrl_param: RTL

Parametrised SRAM controller between the MEM stage and an external narrow-word asynchronous SRAM. It replaces the single-cycle data memory. A DATA_W-bit access is split into DATA_W/SRAM_DW sequential SRAM beats, each lasting a configurable number of cycles. While an access is in flight, `ready` is held low so the top level can freeze the IF/ID/EXE/MEM pipeline.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_ctrl_param_timer.sv | 42 ++++
 rtl/sram_ctrl_param.sv | 112 +++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and address helpers for the parametrised narrow-SRAM controller.
package sram_pkg;

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    function automatic int beats(input int data_w, input int sram_dw);
        return data_w / sram_dw;
    endfunction

    function automatic int byte_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Addresses below the base wrap through unsigned subtraction; the caller truncates.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input int          shift);
        return (addr - base) >> shift;
    endfunction

endpackage

// File: rtl/sram_ctrl_param_timer.sv
// Beat timer: cnt runs 0..WAIT_CYC inside each beat, beat runs 0..N-1 per access.
module sram_beat_timer #(
    parameter int N        = 2,
    parameter int WAIT_CYC = 1,
    parameter int BW       = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_run,
    output logic [BW-1:0] o_beat,
    output logic          o_beat_last,
    output logic          o_access_last
);

    logic [3:0]    r_cnt;
    logic [BW-1:0] r_beat;
    logic          w_beat_last;
    logic          w_access_last;

    assign w_beat_last   = (r_cnt == 4'(WAIT_CYC));
    assign w_access_last = w_beat_last && (r_beat == BW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || i_start) begin
            r_cnt  <= 4'd0;
            r_beat <= '0;
        end else if (i_run) begin
            if (w_beat_last) begin
                r_cnt <= 4'd0;
                if (!w_access_last) r_beat <= r_beat + BW'(1);
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_beat        = r_beat;
    assign o_beat_last   = w_beat_last;
    assign o_access_last = w_access_last;

endmodule

// File: rtl/sram_ctrl_param.sv
// Splits one DATA_W access into N narrow SRAM beats and freezes the pipeline meanwhile.
//   state | meaning
//   IDLE  | waiting; a request latches op/word/wdata and freezes this same cycle
//   BEAT  | driving SRAM beats, WAIT_CYC+1 cycles each
//   DONE  | one cycle with ready=1, rdata valid after a read
module sram_ctrl_param
    import sram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SRAM_DW   = 16,
    parameter int SRAM_AW   = 18,
    parameter int WAIT_CYC  = 1,
    parameter int BASE_ADDR = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_o,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int N          = beats(DATA_W, SRAM_DW);
    localparam int BYTE_SHIFT = byte_shift(DATA_W);
    localparam int BW         = (N > 1) ? $clog2(N) : 1;

    state_t            r_state, w_next;
    op_t               r_op;
    logic [31:0]       r_word;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_req;
    logic              w_start;
    logic              w_wr_beat;
    logic [BW-1:0]     w_beat;
    logic              w_beat_last;
    logic              w_access_last;

    assign w_req     = rd_en | wr_en;
    assign w_start   = (r_state == IDLE) && w_req;
    assign w_wr_beat = (r_state == BEAT) && (r_op == OP_WR);

    sram_beat_timer #(
        .N        (N),
        .WAIT_CYC (WAIT_CYC),
        .BW       (BW)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_start       (w_start),
        .i_run         (r_state == BEAT),
        .o_beat        (w_beat),
        .o_beat_last   (w_beat_last),
        .o_access_last (w_access_last)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        case (r_state)
            IDLE: begin
                ready = !w_req;
                if (w_req) w_next = BEAT;
            end
            BEAT: if (w_access_last) w_next = DONE;
            DONE: begin
                ready  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Write wins when both enables are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_RD;
            r_word  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_op    <= wr_en ? OP_WR : OP_RD;
                r_word  <= word_index(address, 32'(BASE_ADDR), BYTE_SHIFT);
                r_wdata <= wdata;
            end
            if ((r_state == BEAT) && (r_op == OP_RD) && w_beat_last)
                r_rdata[int'(w_beat)*SRAM_DW +: SRAM_DW] <= sram_dq_i;
        end
    end

    // Truncation to SRAM_AW gives the modulo wrap of the word index.
    assign sram_addr  = SRAM_AW'(r_word * 32'(N)) + SRAM_AW'(w_beat);
    assign sram_dq_o  = w_wr_beat ? r_wdata[int'(w_beat)*SRAM_DW +: SRAM_DW] : '0;
    assign sram_dq_oe = w_wr_beat;
    // we_n rises in the last cycle of the beat so data is held across the edge.
    assign sram_we_n  = !(w_wr_beat && ((WAIT_CYC == 0) || !w_beat_last));
    assign rdata      = r_rdata;

endmodule
